jtag_regbank: RTL and testbench



---
 rtl/jtag_regbank.sv | 128 ++++++++++++
 tb/tb_jtag_regbank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/jtag_regbank.sv
// JTAG user-DR register bank. Each scan captures one read word and writes one write word.
// Scans can be length-checked, and an auto-increment mode walks the pointers for burst access.
module jtag_regbank #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 15,
   parameter int ADDR_W   = 4
) (
   input  logic                         iTCK,
   input  logic                         iRESET,
   input  logic [2*ADDR_W+1:0]          iADDRESS,
   input  logic                         iTDI,
   input  logic                         iSTATE_CDR,
   input  logic                         iSTATE_SDR,
   input  logic                         iSTATE_UDR,
   input  logic [NUM_REGS*DATA_W-1:0]   iREAD,
   output logic [NUM_REGS*DATA_W-1:0]   oWRITE,
   output logic [NUM_REGS-1:0]          oWRITE_STB,
   output logic                         oLEN_ERR,
   output logic                         oTDO
);

   localparam int CW = $clog2(DATA_W + 2);
   localparam logic [CW-1:0]     LP_FULL = CW'(DATA_W);
   localparam logic [CW-1:0]     LP_SAT  = CW'(DATA_W + 1);
   localparam logic [ADDR_W-1:0] LP_NUM  = ADDR_W'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_REGS - 1);

   logic                 w_valid, w_autoinc, w_same, w_do_write;
   logic [ADDR_W-1:0]    w_waddr, w_raddr, w_eff_rptr, w_eff_wptr;
   logic [DATA_W-1:0]    w_read [NUM_REGS];
   logic [DATA_W-1:0]    w_cap;

   logic [DATA_W-1:0]    r_work;
   logic [CW-1:0]        r_cnt;
   logic [ADDR_W-1:0]    r_rptr, r_wptr;
   logic [2*ADDR_W+1:0]  r_last_addr;
   logic                 r_len_err;

   assign w_valid   = iADDRESS[2*ADDR_W+1];
   assign w_autoinc = iADDRESS[2*ADDR_W];
   assign w_waddr   = iADDRESS[2*ADDR_W-1:ADDR_W];
   assign w_raddr   = iADDRESS[ADDR_W-1:0];

   // A repeated auto-increment address continues the burst from the internal pointers.
   assign w_same     = w_autoinc && (iADDRESS == r_last_addr);
   assign w_eff_rptr = w_same ? r_rptr : w_raddr;
   assign w_eff_wptr = w_same ? r_wptr : w_waddr;

   assign w_do_write = iSTATE_UDR && !iSTATE_CDR && !iSTATE_SDR && w_valid && (r_cnt == LP_FULL);

   function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] p);
      if (p >= LP_NUM)
         return p;
      else if (p == LP_LAST)
         return '0;
      else
         return p + ADDR_W'(1);
   endfunction

   always_comb begin
      w_cap = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (w_eff_rptr == ADDR_W'(k))
            w_cap = w_read[k];
      end
   end

   always_ff @(posedge iTCK) begin
      if (iRESET) begin
         r_work      <= '0;
         r_cnt       <= '0;
         r_rptr      <= '0;
         r_wptr      <= '0;
         r_last_addr <= '1;
         r_len_err   <= 1'b0;
      end else if (iSTATE_CDR) begin
         r_cnt <= '0;
         if (w_valid) begin
            r_work      <= w_cap;
            r_rptr      <= w_eff_rptr;
            r_wptr      <= w_eff_wptr;
            r_last_addr <= iADDRESS;
         end else begin
            r_work <= '0;
         end
      end else if (iSTATE_SDR) begin
         r_work <= {iTDI, r_work[DATA_W-1:1]};
         if (r_cnt != LP_SAT)
            r_cnt <= r_cnt + CW'(1);
      end else if (iSTATE_UDR && w_valid) begin
         if (r_cnt != LP_FULL) begin
            r_len_err <= 1'b1;
         end else if (w_autoinc) begin
            r_rptr <= f_inc(r_rptr);
            r_wptr <= f_inc(r_wptr);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [DATA_W-1:0] r_write;
         logic              r_stb;

         assign w_read[gi] = iREAD[gi*DATA_W +: DATA_W];

         always_ff @(posedge iTCK) begin
            if (iRESET) begin
               r_write <= '0;
               r_stb   <= 1'b0;
            end else begin
               r_stb <= 1'b0;
               if (w_do_write && (r_wptr == ADDR_W'(gi))) begin
                  r_write <= r_work;
                  r_stb   <= 1'b1;
               end
            end
         end

         assign oWRITE[gi*DATA_W +: DATA_W] = r_write;
         assign oWRITE_STB[gi]              = r_stb;
      end
   endgenerate

   assign oLEN_ERR = r_len_err;
   assign oTDO     = r_work[0];

endmodule

// File: tb/tb_jtag_regbank.sv
// Directed bench for jtag_regbank: scans are driven through a task, and each result is
// compared against a hand-computed value.
module tb_jtag_regbank;

   localparam int DW = 32;
   localparam int NR = 15;
   localparam int AW = 4;

   logic              iTCK = 1'b0;
   logic              iRESET;
   logic [2*AW+1:0]   iADDRESS;
   logic              iTDI;
   logic              iSTATE_CDR, iSTATE_SDR, iSTATE_UDR;
   logic [NR*DW-1:0]  iREAD;
   logic [NR*DW-1:0]  oWRITE;
   logic [NR-1:0]     oWRITE_STB;
   logic              oLEN_ERR;
   logic              oTDO;

   int n_vec = 0;
   int n_bad = 0;

   jtag_regbank #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
      .iTCK(iTCK), .iRESET(iRESET), .iADDRESS(iADDRESS), .iTDI(iTDI),
      .iSTATE_CDR(iSTATE_CDR), .iSTATE_SDR(iSTATE_SDR), .iSTATE_UDR(iSTATE_UDR),
      .iREAD(iREAD), .oWRITE(oWRITE), .oWRITE_STB(oWRITE_STB),
      .oLEN_ERR(oLEN_ERR), .oTDO(oTDO)
   );

   always #5 iTCK = ~iTCK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge iTCK);
      #1;
   endtask

   function automatic logic [DW-1:0] wr(input int k);
      return oWRITE[k*DW +: DW];
   endfunction

   task automatic do_reset();
      iRESET = 1'b1;
      tick();
      iRESET = 1'b0;
   endtask

   // Full scan: capture, n shifts of din (LSB first), update. cap holds the TDO stream.
   task automatic scan(input logic [2*AW+1:0] addr, input logic [DW-1:0] din,
                       input int n, output logic [DW-1:0] cap);
      cap = '0;
      iADDRESS = addr;
      iSTATE_CDR = 1'b1;
      tick();
      iSTATE_CDR = 1'b0;
      iSTATE_SDR = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (i < DW) cap[i] = oTDO;
         iTDI = din[i % DW];
         tick();
      end
      iSTATE_SDR = 1'b0;
      iSTATE_UDR = 1'b1;
      tick();
      iSTATE_UDR = 1'b0;
   endtask

   logic [DW-1:0] cap;
   logic [DW-1:0] rd [NR];

   initial begin
      iRESET = 1'b0; iADDRESS = '0; iTDI = 1'b0;
      iSTATE_CDR = 1'b0; iSTATE_SDR = 1'b0; iSTATE_UDR = 1'b0;
      for (int k = 0; k < NR; k++) begin
         rd[k] = 32'hA000_0000 | (32'h0000_1111 * k);
      end
      rd[5] = 32'hDEADBEEF;
      for (int k = 0; k < NR; k++) iREAD[k*DW +: DW] = rd[k];

      do_reset();
      check("rst_write", 64'(oWRITE == '0), 64'd1);
      check("rst_stb", 64'(oWRITE_STB), 64'd0);
      check("rst_lenerr", 64'(oLEN_ERR), 64'd0);
      check("rst_tdo", 64'(oTDO), 64'd0);

      // Basic read of reg 5 and write of reg 3
      scan(10'b10_0011_0101, 32'h12345678, 32, cap);
      check("t1_cap", 64'(cap), 64'hDEADBEEF);
      check("t1_w3", 64'(wr(3)), 64'h12345678);
      check("t1_stb", 64'(oWRITE_STB), 64'h0008);
      check("t1_err", 64'(oLEN_ERR), 64'd0);
      tick();
      check("t1_stb_off", 64'(oWRITE_STB), 64'h0000);

      // Short scan is rejected; the next correct scan writes and the error stays sticky
      scan(10'b10_0011_0101, 32'h0BAD0BAD, 31, cap);
      check("t2_w3_keep", 64'(wr(3)), 64'h12345678);
      check("t2_stb", 64'(oWRITE_STB), 64'h0000);
      check("t2_err", 64'(oLEN_ERR), 64'd1);
      scan(10'b10_0011_0101, 32'hCAFEF00D, 32, cap);
      check("t2_w3_new", 64'(wr(3)), 64'hCAFEF00D);
      check("t2_stb_new", 64'(oWRITE_STB), 64'h0008);
      check("t2_err_sticky", 64'(oLEN_ERR), 64'd1);

      // Long scan is rejected too
      do_reset();
      scan(10'b10_0011_0101, 32'h11111111, 33, cap);
      check("t7_w3", 64'(wr(3)), 64'd0);
      check("t7_err", 64'(oLEN_ERR), 64'd1);

      // Auto-increment burst wrapping 13 -> 14 -> 0
      do_reset();
      scan(10'b11_1101_1101, 32'hAAAA0001, 32, cap);
      check("t3_cap13", 64'(cap), 64'(rd[13]));
      check("t3_w13", 64'(wr(13)), 64'hAAAA0001);
      check("t3_stb13", 64'(oWRITE_STB), 64'h2000);
      scan(10'b11_1101_1101, 32'hBBBB0002, 32, cap);
      check("t3_cap14", 64'(cap), 64'(rd[14]));
      check("t3_w14", 64'(wr(14)), 64'hBBBB0002);
      check("t3_stb14", 64'(oWRITE_STB), 64'h4000);
      scan(10'b11_1101_1101, 32'hCCCC0003, 32, cap);
      check("t3_cap0", 64'(cap), 64'(rd[0]));
      check("t3_w0", 64'(wr(0)), 64'hCCCC0003);
      check("t3_stb0", 64'(oWRITE_STB), 64'h0001);
      check("t3_w13_keep", 64'(wr(13)), 64'hAAAA0001);

      // Unused pointers and VALID=0
      do_reset();
      scan(10'b10_1111_1111, 32'h55555555, 32, cap);
      check("t4_cap0", 64'(cap), 64'd0);
      check("t4_nowrite", 64'(oWRITE == '0), 64'd1);
      check("t4_stb", 64'(oWRITE_STB), 64'd0);
      check("t4_err", 64'(oLEN_ERR), 64'd0);
      scan(10'b00_0011_0101, 32'h66666666, 32, cap);
      check("t4_inv_cap", 64'(cap), 64'd0);
      check("t4_inv_w3", 64'(wr(3)), 64'd0);
      check("t4_inv_stb", 64'(oWRITE_STB), 64'd0);
      check("t4_inv_err", 64'(oLEN_ERR), 64'd0);

      // Reset in the middle of a scan aborts it
      do_reset();
      iADDRESS = 10'b10_0011_0101;
      iSTATE_CDR = 1'b1;
      tick();
      iSTATE_CDR = 1'b0;
      iSTATE_SDR = 1'b1;
      for (int i = 0; i < 10; i++) begin
         iTDI = i[0];
         tick();
      end
      iSTATE_SDR = 1'b0;
      do_reset();
      iSTATE_UDR = 1'b1;
      tick();
      iSTATE_UDR = 1'b0;
      check("t5_nowrite", 64'(oWRITE == '0), 64'd1);
      check("t5_stb", 64'(oWRITE_STB), 64'd0);
      check("t5_err", 64'(oLEN_ERR), 64'd1);

      // New address between auto-increment scans reloads the pointers
      do_reset();
      scan(10'b11_0010_0010, 32'h22220002, 32, cap);
      check("t6_cap2", 64'(cap), 64'(rd[2]));
      check("t6_w2", 64'(wr(2)), 64'h22220002);
      scan(10'b11_0111_0111, 32'h77770007, 32, cap);
      check("t6_cap7", 64'(cap), 64'(rd[7]));
      check("t6_w7", 64'(wr(7)), 64'h77770007);
      check("t6_w3", 64'(wr(3)), 64'd0);
      check("t6_stb7", 64'(oWRITE_STB), 64'h0080);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
